alu_rr_arbiter: RTL and testbench

//  Shares one 32-bit ALU between two requesters, e.g. the main datapath and a

---
 rtl/alu_rr_arbiter.sv | 118 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU.
// Each transaction runs IDLE -> EXEC -> RESP; operands are captured when the grant is issued.
module alu_rr_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [3:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [3:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  gnt,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic        last_served_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] result_q;
    logic        zero_q, illegal_q;

    logic        any_req;
    logic        winner;
    logic [31:0] alu_res;
    logic        alu_ill;

    // Handshake: a requester holds req with stable operands until its done
    // pulse; it must drop req during the done (RESP) cycle or it re-requests.
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
            winner = ~last_served_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        alu_ill = 1'b0;
        case (op_q)
            4'd0:    alu_res = a_q + b_q;
            4'd1:    alu_res = a_q - b_q;
            4'd2:    alu_res = a_q | b_q;
            4'd3:    alu_res = a_q & b_q;
            4'd4:    alu_res = {b_q[15:0], 16'h0000};
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_served_q <= ~FIRST_PRIO;
            op_q          <= 4'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            result_q      <= 32'd0;
            zero_q        <= 1'b1;
            illegal_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                owner_q       <= winner;
                last_served_q <= winner;
                op_q          <= winner ? op1 : op0;
                a_q           <= winner ? a1 : a0;
                b_q           <= winner ? b1 : b0;
            end
            if (state_q == EXEC) begin
                result_q  <= alu_res;
                zero_q    <= (alu_res == 32'd0);
                illegal_q <= alu_ill;
            end
        end
    end

    // Grant spans EXEC and RESP; done marks the RESP cycle for the owner only.
    always_comb begin
        busy    = (state_q != IDLE);
        gnt     = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        done0   = (state_q == RESP) && !owner_q;
        done1   = (state_q == RESP) && owner_q;
        result  = result_q;
        zero    = zero_q;
        illegal = illegal_q;
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: table vectors, hand-written corner sequences and
// random transactions checked against a transaction-level model.
module tb_alu_rr_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        done0, done1;
    logic [31:0] result;
    logic        zero, illegal, busy;

    int total;
    int bad;
    int last_served;

    alu_rr_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt(gnt), .done0(done0), .done1(done1),
        .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mask;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          scramble;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        int          exp_w;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the op table with plain arithmetic.
    function automatic logic [32:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned r;
        r = 0;
        if (op == 0) r = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
        else if (op == 1) r = (64'h1_0000_0000 + longint'(a) - longint'(b)) % 64'h1_0000_0000;
        else if (op == 2) r = a | b;
        else if (op == 3) r = a & b;
        else if (op == 4) r = (longint'(b) % 65536) * 65536;
        else return {1'b1, 32'd0};
        return {1'b0, r[31:0]};
    endfunction

    function automatic int model_winner(input logic [1:0] mask);
        if (mask == 2'b11) return 1 - last_served;
        return mask[1] ? 1 : 0;
    endfunction

    // Driver: called at a negedge with the DUT idle; returns at a negedge idle.
    task automatic txn(input logic [1:0] mask,
                       input logic [3:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                       input logic [3:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                       input bit scramble,
                       input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill,
                       input int exp_w);
        logic [1:0] exp_gnt;
        exp_gnt = (exp_w == 1) ? 2'b10 : 2'b01;
        req0 = mask[0]; op0 = o0; a0 = x0; b0 = y0;
        req1 = mask[1]; op1 = o1; a1 = x1; b1 = y1;
        @(posedge clk); @(negedge clk);
        chk("exec_gnt", {30'd0, gnt}, {30'd0, exp_gnt});
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_no_done", {30'd0, done1, done0}, 32'd0);
        if (scramble) begin
            op0 = 4'($urandom_range(5, 15)); a0 = 32'hFFFF_FFFF; b0 = $urandom;
            op1 = 4'($urandom_range(5, 15)); a1 = 32'hFFFF_FFFF; b1 = $urandom;
        end
        @(posedge clk); @(negedge clk);
        chk("resp_done", {30'd0, done1, done0}, {30'd0, exp_gnt});
        chk("resp_gnt", {30'd0, gnt}, {30'd0, exp_gnt});
        chk("result", result, exp_res);
        chk("zero", {31'd0, zero}, {31'd0, exp_zero});
        chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_gnt", {30'd0, gnt}, 32'd0);
        chk("idle_no_done", {30'd0, done1, done0}, 32'd0);
        chk("result_hold", result, exp_res);
        last_served = exp_w;
    endtask

    task automatic add_vec(input logic [1:0] mask, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit scr, input logic [31:0] er,
                           input logic ez, input logic ei, input int ew);
        vec_t v;
        v.mask = mask; v.op = op; v.a = a; v.b = b; v.scramble = scr;
        v.exp_res = er; v.exp_zero = ez; v.exp_ill = ei; v.exp_w = ew;
        vecs.push_back(v);
    endtask

    initial begin
        logic [32:0] m;
        logic [1:0]  mask;
        logic [3:0]  ro0, ro1;
        logic [31:0] ra0, rb0, ra1, rb1;
        int          w;
        int          exp_seq[4];

        total = 0; bad = 0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        last_served = 1;

        // Both requests held high across four transactions: 0,1,0,1.
        exp_seq = '{0, 1, 0, 1};
        req0 = 1; op0 = 4'd0; a0 = 32'd1;  b0 = 32'd2;
        req1 = 1; op1 = 4'd1; a1 = 32'd10; b1 = 32'd3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("rr_gnt", {30'd0, gnt}, (exp_seq[k] == 1) ? 32'd2 : 32'd1);
            @(posedge clk); @(negedge clk);
            chk("rr_done", {30'd0, done1, done0}, (exp_seq[k] == 1) ? 32'd2 : 32'd1);
            chk("rr_result", result, (exp_seq[k] == 1) ? 32'd7 : 32'd3);
            @(posedge clk); @(negedge clk);
            chk("rr_idle", {31'd0, busy}, 32'd0);
        end
        req0 = 0; req1 = 0;
        last_served = 1;
        @(posedge clk); @(negedge clk);

        // Directed vectors
        add_vec(2'b01, 4'd0, 32'd7, 32'd5, 0, 32'd12, 0, 0, 0);
        add_vec(2'b10, 4'd1, 32'd5, 32'd5, 0, 32'd0, 1, 0, 1);
        add_vec(2'b10, 4'd4, 32'd0, 32'h1234, 0, 32'h1234_0000, 0, 0, 1);
        add_vec(2'b01, 4'd7, 32'd3, 32'd3, 0, 32'd0, 1, 1, 0);
        add_vec(2'b01, 4'd2, 32'hF0, 32'h0F, 0, 32'hFF, 0, 0, 0);
        add_vec(2'b01, 4'd0, 32'd1, 32'd1, 1, 32'd2, 0, 0, 0);
        add_vec(2'b01, 4'd0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1, 0, 0);
        add_vec(2'b10, 4'd3, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 0, 1);
        add_vec(2'b10, 4'd15, 32'd9, 32'd9, 1, 32'd0, 1, 1, 1);
        add_vec(2'b01, 4'd1, 32'd0, 32'd1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        foreach (vecs[i]) begin
            txn(vecs[i].mask, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].scramble,
                vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_ill, vecs[i].exp_w);
        end

        // Random transactions against the model
        for (int n = 0; n < 60; n++) begin
            mask = 2'($urandom_range(1, 3));
            ro0 = 4'($urandom_range(0, 6)); ra0 = $urandom; rb0 = $urandom;
            ro1 = 4'($urandom_range(0, 6)); ra1 = $urandom; rb1 = $urandom;
            if ($urandom_range(0, 3) == 0) rb0 = ra0;
            w = model_winner(mask);
            m = (w == 1) ? model_alu(ro1, ra1, rb1) : model_alu(ro0, ra0, rb0);
            txn(mask, ro0, ra0, rb0, ro1, ra1, rb1, 1'($urandom_range(0, 1)),
                m[31:0], (m[31:0] == 32'd0), m[32], w);
        end

        // Reset during EXEC discards the in-flight op.
        req0 = 1; op0 = 4'd0; a0 = 32'd100; b0 = 32'd23;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; req0 = 0;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_gnt", {30'd0, gnt}, 32'd0);
        chk("midrst_done", {30'd0, done1, done0}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        reset = 1'b0;
        last_served = 1;
        @(posedge clk); @(negedge clk);
        chk("postrst_done", {30'd0, done1, done0}, 32'd0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);

        // After reset a tie goes to requester 0 again.
        w = model_winner(2'b11);
        m = model_alu(4'd2, 32'h0A, 32'h50);
        txn(2'b11, 4'd2, 32'h0A, 32'h50, 4'd0, 32'd1, 32'd1, 0, m[31:0], (m[31:0] == 0), m[32], w);
        chk("post_rst_winner", w, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
